doorlock_fsm: RTL
=================

// Module: doorlock_fsm
// PURPOSE
//  Password-entry controller for the DE0 door lock. It sits directly downstream of the multibit key
//  debouncer and consumes its debounced, active-low key levels. It detects key presses, collects a
//  PW_LEN-digit code and compares it with PASSWORD on ENTER. It drives the unlock, error and lockout
//  indications with fixed-duration timers.
// PARAMETERS
//  PW_LEN    4                 digits per code, 1..7
//  PASSWORD  8'b00_01_10_00    expected code, 2 bits/digit, first digit in MSBs, width 2*PW_LEN
//  MAX_FAIL  3                 consecutive failures that trigger lockout, 1..3
//  CNT_W     28                timer width
//  T_OPEN    28'd150_000_000   unlock duration in clk cycles (3 s at 50 MHz)
//  T_ERR     28'd25_000_000    error indication duration (0.5 s)
//  T_LOCK    28'd250_000_000   lockout duration (5 s)
// PORTS
//  clk        in   1         system clock, 50 MHz
//  rst        in   1         asynchronous, active-high reset
//  key_n      in   4         debounced key levels, 0 = pressed; [2:0] digit keys 0..2, [3] ENTER
//  door_open  out  1         high while unlocked
//  err        out  1         high while a failed attempt is indicated
//  locked     out  1         high during lockout
//  digit_cnt  out  3         digits entered so far, saturates at PW_LEN
//  fail_cnt   out  2         consecutive failed attempts
// BEHAVIOUR
//  - Reset: key_d1 = 4'b0000; state = IDLE; timer, entry shift reg, overflow/multi flags = 0.
//    All outputs are 0 during and after reset.
//  - Press detect: press[i] = key_d1[i] & ~key_n[i], where key_d1 is key_n registered one cycle.
//    Because key_d1 resets to 0, a debouncer output of 0 after reset produces no press.
//    A key held across reset must be released and pressed again to be recognised.
//  - Latency: press is seen in cycle t; the state, counters and outputs update at the clk edge ending t.
//    All outputs are registered.
//  - Simultaneous presses in one cycle:
//    - ENTER plus a digit: ENTER is processed and the digit is discarded.
//    - Two or more digits: digit_cnt still increments once, and the multi flag is set.
//  - Digit press: shifts the 2-bit digit value into the entry register and increments digit_cnt.
//    If digit_cnt is already PW_LEN, the entry is unchanged, digit_cnt holds and the ovf flag is set.
//  - States:
//    - IDLE: a digit press goes to ENTRY and records the digit. An ENTER press is ignored.
//    - ENTRY: a digit press records the digit. On an ENTER press:
//      - match (digit_cnt==PW_LEN, entry==PASSWORD, ovf=0, multi=0): go to OPEN, timer = T_OPEN-1,
//        fail_cnt = 0.
//      - no match, fail_cnt+1 < MAX_FAIL: go to ERR, timer = T_ERR-1, fail_cnt increments.
//      - no match, fail_cnt+1 == MAX_FAIL: go to LOCK, timer = T_LOCK-1, fail_cnt = 0.
//      - Every ENTER clears the entry register, digit_cnt, ovf and multi.
//    - OPEN: door_open=1 while the timer counts down. At timer==0 go to IDLE on the next edge.
//      An ENTER press goes to IDLE at once (early relock). Digit presses are ignored.
//    - ERR: err=1, count down, at timer==0 go to IDLE. All presses are ignored.
//    - LOCK: locked=1, count down, at timer==0 go to IDLE. All presses are ignored.
//  - Each timed state lasts exactly T_x cycles. door_open, err and locked are mutually exclusive.
//  - The timer decrements only in OPEN, ERR and LOCK. It is 0 in IDLE and ENTRY.
//  - Reset asserted mid-state aborts immediately to the reset values. There is no partial-entry retention.
// TESTING
//  1 Reset with key_n=4'h0, then release to 4'hF: no press, state IDLE, all outputs 0.
//  2 Digits 0,1,2,0 then ENTER, T_OPEN=10: door_open=1 for exactly 10 cycles starting the edge after
//    the ENTER press, then IDLE with digit_cnt=0 and fail_cnt=0.
//  3 Wrong code twice, T_ERR=4: err pulses of 4 cycles each, fail_cnt goes 1 then 2.
//    Third wrong code: locked=1 for T_LOCK cycles, fail_cnt=0. Presses during lockout are ignored.
//  4 Five digits where the first four match, then ENTER: digit_cnt saturates at 4, ovf is set,
//    the result is ERR, and fail_cnt increments.
//  5 Keys 0 and 1 pressed in the same cycle during entry leads to ERR at ENTER.
//    ENTER pressed together with digit 2 in ENTRY: the digit is discarded and the check runs.
//  6 ENTER pressed in OPEN leads to IDLE the next edge. Reset asserted in ENTRY with digit_cnt=3
//    returns digit_cnt to 0 asynchronously.

Source files
------------

// File: rtl/doorlock_fsm.sv
// Door lock password controller: detects debounced key presses, collects a
// PW_LEN-digit code, checks it on ENTER and times the unlock, error and
// lockout indications.
module doorlock_fsm #(
  parameter int unsigned              PW_LEN   = 4,
  parameter logic [2*PW_LEN-1:0]      PASSWORD = 8'b00_01_10_00,
  parameter int unsigned              MAX_FAIL = 3,
  parameter int unsigned              CNT_W    = 28,
  parameter logic [CNT_W-1:0]         T_OPEN   = 28'd150_000_000,
  parameter logic [CNT_W-1:0]         T_ERR    = 28'd25_000_000,
  parameter logic [CNT_W-1:0]         T_LOCK   = 28'd250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       door_open,
  output logic       err,
  output logic       locked,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  localparam int unsigned ENTRY_W = 2 * PW_LEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_OPEN  = 3'd2,
    S_ERR   = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t             state;
  logic [3:0]         key_d1;
  logic [CNT_W-1:0]   timer;
  logic [ENTRY_W-1:0] entry;
  logic               ovf;
  logic               multi;

  logic [3:0]         press;
  logic               enter_press;
  logic               dig_any;
  logic               dig_multi;
  logic [1:0]         dig_val;
  logic               code_ok;
  logic [2:0]         fail_next;

  // Falling edge of a debounced active-low key level is a press.
  assign press       = key_d1 & ~key_n;
  assign enter_press = press[3];
  assign dig_any     = |press[2:0];
  assign dig_multi   = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
  // With several digits pressed at once the code is spoiled by multi, so the value is arbitrary.
  assign dig_val     = press[0] ? 2'd0 : (press[1] ? 2'd1 : 2'd2);
  assign code_ok     = (digit_cnt == 3'(PW_LEN)) && (entry == PASSWORD) && !ovf && !multi;
  assign fail_next   = 3'(fail_cnt) + 3'd1;

  // Key level history for press detection; resets low so a held key is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_d1 <= 4'b0000;
    else     key_d1 <= key_n;
  end

  // Main controller: state, entry collection, timers and registered indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      entry     <= '0;
      ovf       <= 1'b0;
      multi     <= 1'b0;
      door_open <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
      digit_cnt <= 3'd0;
      fail_cnt  <= 2'd0;
    end else begin
      case (state)
        S_IDLE, S_ENTRY: begin
          if (enter_press) begin
            // ENTER wins over any digit in the same cycle; in IDLE it does nothing.
            if (state == S_ENTRY) begin
              entry     <= '0;
              digit_cnt <= 3'd0;
              ovf       <= 1'b0;
              multi     <= 1'b0;
              if (code_ok) begin
                state     <= S_OPEN;
                timer     <= T_OPEN - CNT_W'(1);
                fail_cnt  <= 2'd0;
                door_open <= 1'b1;
              end else if (fail_next < 3'(MAX_FAIL)) begin
                state    <= S_ERR;
                timer    <= T_ERR - CNT_W'(1);
                fail_cnt <= 2'(fail_next);
                err      <= 1'b1;
              end else begin
                state    <= S_LOCK;
                timer    <= T_LOCK - CNT_W'(1);
                fail_cnt <= 2'd0;
                locked   <= 1'b1;
              end
            end
          end else if (dig_any) begin
            state <= S_ENTRY;
            if (dig_multi) multi <= 1'b1;
            if (digit_cnt == 3'(PW_LEN)) begin
              ovf <= 1'b1;
            end else begin
              entry     <= ENTRY_W'({entry, dig_val});
              digit_cnt <= digit_cnt + 3'd1;
            end
          end
        end

        S_OPEN: begin
          if (enter_press || timer == '0) begin
            state     <= S_IDLE;
            timer     <= '0;
            door_open <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end

        S_ERR: begin
          if (timer == '0) begin
            state <= S_IDLE;
            err   <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end

        S_LOCK: begin
          if (timer == '0) begin
            state  <= S_IDLE;
            locked <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          timer     <= '0;
          door_open <= 1'b0;
          err       <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
